matrix_bus_sequencer: RTL and testbench

Front-end sequencer for the 4x4 matrix multiply engine. It collects 32 16-bit elements from a narrow valid/ready stream: matrix A first, then matrix B. It presents each matrix as one 256-bit word on the multiplier's operand bus, then captures the 256-bit result word and streams it back out as 16 elements with backpressure.

---
 rtl/matrix_bus_sequencer.sv | 139 +++++++++++++
 tb/tb_matrix_bus_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_bus_sequencer.sv
// Front-end sequencer for the 4x4 matrix multiply engine: loads A then B from a 16-bit stream,
// strobes both onto the operand bus, captures the result and drains it. Option: MATSEQ_DONE_CNT_EN.
module matrix_bus_sequencer #(
  parameter int RESULT_WAIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [15:0]  in_data,
  output logic [255:0] mm_bus_out,
  output logic         mm_bus_strobe,
  input  logic [255:0] mm_result_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_data,
  output logic         out_last,
  output logic         busy
`ifdef MATSEQ_DONE_CNT_EN
  ,
  output logic [15:0]  done_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // Terminal value of the wait counter; unused when RESULT_WAIT is 0.
  localparam logic [3:0] WAIT_LAST = (RESULT_WAIT > 0) ? 4'(RESULT_WAIT - 1) : 4'd0;

  state_t         state;
  state_t         state_nxt;
  logic [4:0]     ld_cnt;
  logic [3:0]     wt_cnt;
  logic [3:0]     dr_cnt;
  logic [255:0]   a_mat;
  logic [255:0]   b_mat;
  logic [255:0]   r_mat;
  logic           ld_fire;
  logic           ld_done;
  logic           dr_fire;
  logic           dr_done;

  assign ld_fire = (state == ST_LOAD) & in_valid;
  assign ld_done = ld_fire & (ld_cnt == 5'd31);
  assign dr_fire = (state == ST_DRAIN) & out_ready;
  assign dr_done = dr_fire & (dr_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = ST_LOAD;
      ST_LOAD:    if (ld_done) state_nxt = ST_SEND_A;
      ST_SEND_A:  state_nxt = ST_SEND_B;
      ST_SEND_B:  state_nxt = (RESULT_WAIT > 0) ? ST_WAIT : ST_CAPTURE;
      ST_WAIT:    if (wt_cnt == WAIT_LAST) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_DRAIN;
      ST_DRAIN:   if (dr_done) state_nxt = ST_LOAD;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_cnt <= 5'd0;
      wt_cnt <= 4'd0;
      dr_cnt <= 4'd0;
    end else begin
      if (ld_fire) begin
        ld_cnt <= ld_cnt + 5'd1;
      end
      if (state == ST_WAIT) begin
        wt_cnt <= (wt_cnt == WAIT_LAST) ? 4'd0 : wt_cnt + 4'd1;
      end
      if (dr_fire) begin
        dr_cnt <= dr_cnt + 4'd1;
      end
    end
  end

  // The bus is loaded on the edge entering each send state, so it already holds the operand
  // during the strobe cycle and keeps it afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_bus_out <= '0;
    end else if (ld_done) begin
      mm_bus_out <= a_mat;
    end else if (state == ST_SEND_A) begin
      mm_bus_out <= b_mat;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      if (!ld_cnt[4]) begin
        a_mat[{ld_cnt[3:0], 4'b0000} +: 16] <= in_data;
      end else begin
        b_mat[{ld_cnt[3:0], 4'b0000} +: 16] <= in_data;
      end
    end
    if (state == ST_CAPTURE) begin
      r_mat <= mm_result_in;
    end
  end

`ifdef MATSEQ_DONE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 16'd0;
    end else if (dr_done) begin
      done_cnt <= done_cnt + 16'd1;
    end
  end
`endif

  // Result data is gated outside DRAIN so the unreset result register never shows on out_data.
  assign in_ready      = (state == ST_LOAD);
  assign mm_bus_strobe = (state == ST_SEND_A) | (state == ST_SEND_B);
  assign out_valid     = (state == ST_DRAIN);
  assign out_last      = (state == ST_DRAIN) & (dr_cnt == 4'd15);
  assign out_data      = (state == ST_DRAIN) ? r_mat[{dr_cnt, 4'b0000} +: 16] : 16'h0000;
  assign busy          = ~((state == ST_IDLE) | ((state == ST_LOAD) & (ld_cnt == 5'd0)));

endmodule

// File: tb/tb_matrix_bus_sequencer.sv
// Scoreboard bench for matrix_bus_sequencer; a second instance with RESULT_WAIT=0 shares the inputs.
// Exercises the done counter when MATSEQ_DONE_CNT_EN is defined.
module tb_matrix_bus_sequencer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         out_ready;
  logic         one = 1'b1;
  logic [255:0] mm_result_in;

  logic         in_ready, mm_bus_strobe, out_valid, out_last, busy;
  logic [255:0] mm_bus_out;
  logic [15:0]  out_data;
  logic         in_ready0, mm_bus_strobe0, out_valid0, out_last0, busy0;
  logic [255:0] mm_bus_out0;
  logic [15:0]  out_data0;
`ifdef MATSEQ_DONE_CNT_EN
  logic [15:0]  done_cnt, done_cnt0;
`endif

  always #5 clk = ~clk;

  matrix_bus_sequencer #(.RESULT_WAIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_bus_out(mm_bus_out), .mm_bus_strobe(mm_bus_strobe), .mm_result_in(mm_result_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
`ifdef MATSEQ_DONE_CNT_EN
    , .done_cnt(done_cnt)
`endif
  );

  matrix_bus_sequencer #(.RESULT_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .mm_bus_out(mm_bus_out0), .mm_bus_strobe(mm_bus_strobe0), .mm_result_in(mm_result_in),
    .out_valid(out_valid0), .out_ready(one), .out_data(out_data0), .out_last(out_last0),
    .busy(busy0)
`ifdef MATSEQ_DONE_CNT_EN
    , .done_cnt(done_cnt0)
`endif
  );

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } out_t;

  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [255:0] exp_bus[$];
  out_t         exp_out[$];
  logic [15:0]  va[32];
  int           sa_cyc = -1, sb_cyc = -1, ov_cyc = -1, ov0_cyc = -1;
  logic [15:0]  od0_first = 16'h0;
  logic         prev_ov = 1'b0, prev_ov0 = 1'b0;

  logic [255:0] w_ident, w_seq, w_ident2, w_b3, w_r6, w_rev;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endfunction

  function automatic void flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event, expected none", name);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expected bus words on strobes and peeks/pops expected result elements.
  initial forever begin
    @(negedge clk);
    if (mm_bus_strobe) begin
      sa_cyc = sb_cyc;
      sb_cyc = cyc;
      if (exp_bus.size() == 0) flag("unexpected_strobe");
      else check("bus_word", mm_bus_out, exp_bus.pop_front());
    end
    if (out_valid) begin
      if (!prev_ov) ov_cyc = cyc;
      if (exp_out.size() == 0) flag("unexpected_out");
      else begin
        check("out_data", {240'd0, out_data}, {240'd0, exp_out[0].d});
        check("out_last", {255'd0, out_last}, {255'd0, exp_out[0].l});
        if (out_ready) void'(exp_out.pop_front());
      end
    end
    prev_ov = out_valid;
    if (out_valid0 && !prev_ov0) begin
      ov0_cyc = cyc;
      od0_first = out_data0;
    end
    prev_ov0 = out_valid0;
  end

  task automatic chk_reset(input string tag);
    check({tag, "_in_ready"}, {255'd0, in_ready}, 256'd0);
    check({tag, "_bus"}, mm_bus_out, 256'd0);
    check({tag, "_strobe"}, {255'd0, mm_bus_strobe}, 256'd0);
    check({tag, "_out_valid"}, {255'd0, out_valid}, 256'd0);
    check({tag, "_out_data"}, {240'd0, out_data}, 256'd0);
    check({tag, "_out_last"}, {255'd0, out_last}, 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
  endtask

  task automatic prep(input logic [255:0] a, input logic [255:0] b, input logic [255:0] r);
    out_t e;
    exp_bus.push_back(a);
    exp_bus.push_back(b);
    for (int k = 0; k < 16; k++) begin
      e.d = r[16*k +: 16];
      e.l = (k == 15);
      exp_out.push_back(e);
      va[k]      = a[16*k +: 16];
      va[16 + k] = b[16*k +: 16];
    end
    mm_result_in = r;
  endtask

  // Called at posedge+1; returns the cycle count of the edge that accepted the last element.
  task automatic load_elems(input int count, input bit gaps, output int t);
    int i = 0;
    int ph = 0;
    int guard = 0;
    bit acc;
    t = 0;
    while (i < count && guard < 400) begin
      in_valid = gaps ? (ph[0] == 1'b0) : 1'b1;
      ph++;
      in_data = in_valid ? va[i] : 16'h0;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        i++;
        t = cyc;
      end
    end
    in_valid = 1'b0;
    in_data  = 16'h0;
    if (i < count) begin
      vectors++;
      miscompares++;
      $display("FAIL load_timeout: got %0d elements, expected %0d", i, count);
    end
  endtask

  task automatic drain(input int stall_idx);
    int n = 0;
    int stall = 3;
    int guard = 0;
    bit done = 0;
    while (!done && guard < 300) begin
      if (out_valid && n == stall_idx && stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        n++;
        if (n == 16) done = 1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d handshakes, expected 16", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 16'h0;
    out_ready = 1'b1;
    mm_result_in = '0;
    for (int k = 0; k < 16; k++) begin
      w_ident[16*k +: 16]  = (k % 5 == 0) ? 16'd1 : 16'd0;
      w_ident2[16*k +: 16] = (k % 5 == 0) ? 16'd2 : 16'd0;
      w_seq[16*k +: 16]    = 16'(k + 1);
      w_b3[16*k +: 16]     = 16'(3 * (k + 1));
      w_r6[16*k +: 16]     = 16'(6 * (k + 1));
      w_rev[16*k +: 16]    = 16'(16 - k);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    check("in_ready_idle", {255'd0, in_ready}, 256'd0);
    @(posedge clk);
    #1;
    check("in_ready_load", {255'd0, in_ready}, 256'd1);
    check("busy_load_empty", {255'd0, busy}, 256'd0);

    // Identity A times 1..16
    prep(w_ident, w_seq, w_seq);
    load_elems(32, 1'b0, t);
    drain(-1);
    check("id_strobe_a_cyc", 256'(sa_cyc), 256'(t));
    check("id_strobe_b_cyc", 256'(sb_cyc), 256'(t + 1));
    check("id_first_valid_cyc", 256'(ov_cyc), 256'(t + 5));
    check("w0_first_valid_cyc", 256'(ov0_cyc), 256'(t + 3));
    check("w0_first_data", {240'd0, od0_first}, 256'd1);
    check("bus_held", mm_bus_out, w_seq);
    check("busy_after_drain", {255'd0, busy}, 256'd0);

    // Input gaps: 2I times 3k
    prep(w_ident2, w_b3, w_r6);
    load_elems(32, 1'b1, t);
    drain(-1);
    check("gap_strobe_a_cyc", 256'(sa_cyc), 256'(t));
    check("gap_strobe_b_cyc", 256'(sb_cyc), 256'(t + 1));
    check("gap_first_valid_cyc", 256'(ov_cyc), 256'(t + 5));

    // Repeat operand with output backpressure on element 5
    prep(w_ident, w_ident, w_ident);
    load_elems(32, 1'b0, t);
    drain(4);
    check("rep_strobe_a_cyc", 256'(sa_cyc), 256'(t));
    check("rep_strobe_b_cyc", 256'(sb_cyc), 256'(t + 1));

    // Reset after 20 elements
    for (int k = 0; k < 32; k++) va[k] = 16'(16'h0100 + k);
    load_elems(20, 1'b0, t);
    check("busy_partial", {255'd0, busy}, 256'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready_after_rst", {255'd0, in_ready}, 256'd0);
    @(posedge clk);
    #1;
    check("in_ready_rst_load", {255'd0, in_ready}, 256'd1);
    prep(w_ident, w_rev, w_rev);
    load_elems(32, 1'b0, t);
    drain(-1);
    check("rst_strobe_a_cyc", 256'(sa_cyc), 256'(t));
    check("rst_first_valid_cyc", 256'(ov_cyc), 256'(t + 5));

`ifdef MATSEQ_DONE_CNT_EN
    force dut.done_cnt = 16'hFFFE;
    #1;
    release dut.done_cnt;
    prep(w_ident, w_seq, w_seq);
    load_elems(32, 1'b0, t);
    drain(-1);
    check("done_cnt_ffff", {240'd0, done_cnt}, 256'h0FFFF);
    prep(w_ident, w_seq, w_seq);
    load_elems(32, 1'b0, t);
    drain(-1);
    check("done_cnt_wrap", {240'd0, done_cnt}, 256'd0);
`endif

    repeat (2) @(posedge clk);
    #1;
    check("bus_queue_empty", 256'(exp_bus.size()), 256'd0);
    check("out_queue_empty", 256'(exp_out.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
